// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x oversampled UART receiver, 7/8/9 majority vote.
// Define PARITY_CHECK_EN to add an even-parity bit ahead of the stop bit.
module uart_rx_oversampled #(
  parameter int DIV_WIDTH  = 12,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic [DIV_WIDTH-1:0] divisor_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_V0 = OSW'(7);
  localparam logic [OSW-1:0] OS_V1 = OSW'(8);
  localparam logic [OSW-1:0] OS_V2 = OSW'(9);
  localparam logic [OSW-1:0] OS_ONE = OSW'(1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] BIT_ONE = BCW'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PARITY_CHECK_EN
    S_PARITY,
`endif
    S_STOP,
    S_BRK
  } state_t;

  state_t state_q, state_d;

  logic                 rx_meta, rxs;
  logic [DIV_WIDTH-1:0] div_lat, div_in_eff, presc;
  logic [OSW-1:0]       os_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 os_tick, decide, vote;
  logic                 s7, s8, brk_hi;
  logic                 start_det, shift_en;
  logic                 load_en, ovr_en, frm_en;
`ifdef PARITY_CHECK_EN
  logic                 par_en, par_pend;
`endif

  assign div_in_eff = (divisor_in == '0) ? DIV_ONE : divisor_in;
  assign busy       = (state_q != S_IDLE);
  assign os_tick    = busy && (presc == '0);
  assign decide     = os_tick && (os_cnt == OS_V2);
  assign vote       = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

  always_ff @(posedge Clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    shift_en  = 1'b0;
    load_en   = 1'b0;
    ovr_en    = 1'b0;
    frm_en    = 1'b0;
`ifdef PARITY_CHECK_EN
    par_en    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: if (!rxs) begin
        start_det = 1'b1;
        state_d   = S_START;
      end
      S_START: if (decide) state_d = vote ? S_IDLE : S_DATA;
      S_DATA: if (decide) begin
        shift_en = 1'b1;
`ifdef PARITY_CHECK_EN
        if (bit_cnt == BIT_LAST) state_d = S_PARITY;
`else
        if (bit_cnt == BIT_LAST) state_d = S_STOP;
`endif
      end
`ifdef PARITY_CHECK_EN
      S_PARITY: if (decide) begin
        par_en  = 1'b1;
        state_d = S_STOP;
      end
`endif
      // Leave at mid stop bit so a following start edge is not missed
      S_STOP: if (decide) begin
        if (!vote) begin
          frm_en  = 1'b1;
          state_d = S_BRK;
        end else begin
          if (!rx_valid || rx_ready) load_en = 1'b1;
          else                       ovr_en  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_BRK: if (os_tick && rxs && brk_hi) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      div_lat <= DIV_ONE;
      presc   <= '0;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      s7      <= 1'b1;
      s8      <= 1'b1;
      brk_hi  <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
      if (!busy) div_lat <= div_in_eff;
      if (start_det) begin
        presc   <= div_in_eff - DIV_ONE;
        os_cnt  <= '0;
        bit_cnt <= '0;
      end else if (busy) begin
        presc <= (presc == '0) ? div_lat - DIV_ONE : presc - DIV_ONE;
        if (os_tick)
          os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_ONE;
      end
      if (os_tick && os_cnt == OS_V0) s7 <= rxs;
      if (os_tick && os_cnt == OS_V1) s8 <= rxs;
      if (shift_en) begin
        shreg   <= {vote, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + BIT_ONE;
      end
      // Line must stay high across one whole tick interval to leave BRK
      if (state_q != S_BRK || !rxs) brk_hi <= 1'b0;
      else if (os_tick)             brk_hi <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frm_en;
      overrun_err <= ovr_en;
      if (load_en) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge Clk) begin
    if (reset) begin
      par_pend   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (start_det)   par_pend <= 1'b0;
      else if (par_en) par_pend <= vote ^ (^shreg);
      parity_err <= load_en && par_pend;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: directed frames at divisor 4 (64 Clk per bit).
// Parity frames are sent only when PARITY_CHECK_EN is defined.
module tb_uart_rx_oversampled;
  logic        Clk = 1'b0;
  logic        reset;
  logic        rx_in;
  logic [11:0] divisor_in;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;
  logic        overrun_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  int n_rise = 0, n_pe = 0, n_pe_co = 0, n_fe = 0, n_ov = 0;
  int b_rise, b_pe, b_pe_co, b_fe, b_ov;
  logic prev_valid = 1'b0;

  uart_rx_oversampled dut (
    .Clk(Clk), .reset(reset), .rx_in(rx_in),
    .divisor_in(divisor_in), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err),
    .overrun_err(overrun_err), .busy(busy)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (rx_valid && !prev_valid) n_rise <= n_rise + 1;
    if (parity_err) n_pe <= n_pe + 1;
    if (parity_err && rx_valid && !prev_valid) n_pe_co <= n_pe_co + 1;
    if (frame_err) n_fe <= n_fe + 1;
    if (overrun_err) n_ov <= n_ov + 1;
    prev_valid <= rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_rise = n_rise; b_pe = n_pe; b_pe_co = n_pe_co;
    b_fe = n_fe; b_ov = n_ov;
  endtask

  task automatic bit_time(input logic v);
    rx_in = v;
    repeat (64) @(negedge Clk);
  endtask

  task automatic send(input logic [7:0] d, input logic par_flip,
                      input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef PARITY_CHECK_EN
    bit_time((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
    bit_time(stop);
    rx_in = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    rx_in = 1'b1;
    divisor_in = 12'd4;
    rx_ready = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {parity_err, frame_err, overrun_err}, 0);
    reset = 1'b0;
    repeat (20) @(negedge Clk);

    // 1: clean 0xA5
    snap();
    send(8'hA5, 1'b0, 1'b1);
    chk("s1_data", rx_data, 8'hA5);
    chk("s1_rise", n_rise - b_rise, 1);
    chk("s1_valid_clr", rx_valid, 0);
    chk("s1_errs", (n_pe - b_pe) + (n_fe - b_fe) + (n_ov - b_ov), 0);
    chk("s1_busy", busy, 0);

    // 2: 0x3C with wrong parity bit, held by rx_ready=0
    rx_ready = 1'b0;
    snap();
    send(8'h3C, 1'b1, 1'b1);
    chk("s2_data", rx_data, 8'h3C);
    chk("s2_valid", rx_valid, 1);
    chk("s2_rise", n_rise - b_rise, 1);
`ifdef PARITY_CHECK_EN
    chk("s2_pe", n_pe - b_pe, 1);
    chk("s2_pe_co", n_pe_co - b_pe_co, 1);
`else
    chk("s2_pe", n_pe - b_pe, 0);
`endif
    rx_ready = 1'b1;
    repeat (2) @(negedge Clk);
    chk("s2_valid_clr", rx_valid, 0);

    // 3: stop bit 0 then line stuck low
    snap();
    send(8'h5A, 1'b0, 1'b0);
    rx_in = 1'b0;
    repeat (20 * 64) @(negedge Clk);
    chk("s3_fe", n_fe - b_fe, 1);
    chk("s3_rise", n_rise - b_rise, 0);
    chk("s3_busy_low_line", busy, 1);
    rx_in = 1'b1;
    repeat (2) @(negedge Clk);
    chk("s3_busy_rise", busy, 1);
    repeat (30) @(negedge Clk);
    chk("s3_busy_idle", busy, 0);
    snap();
    send(8'h81, 1'b0, 1'b1);
    chk("s3_next_data", rx_data, 8'h81);
    chk("s3_next_rise", n_rise - b_rise, 1);
    chk("s3_next_fe", n_fe - b_fe, 0);

    // 4: 12-Clk glitch
    snap();
    rx_in = 1'b0;
    repeat (12) @(negedge Clk);
    rx_in = 1'b1;
    chk("s4_busy_hi", busy, 1);
    repeat (64) @(negedge Clk);
    chk("s4_busy_lo", busy, 0);
    chk("s4_rise", n_rise - b_rise, 0);
    chk("s4_errs", (n_pe - b_pe) + (n_fe - b_fe) + (n_ov - b_ov), 0);

    // 5: overrun
    rx_ready = 1'b0;
    snap();
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    chk("s5_data", rx_data, 8'h11);
    chk("s5_valid", rx_valid, 1);
    chk("s5_ov", n_ov - b_ov, 1);
    chk("s5_rise", n_rise - b_rise, 1);
    rx_ready = 1'b1;
    repeat (2) @(negedge Clk);
    chk("s5_valid_clr", rx_valid, 0);
    chk("s5_data_held", rx_data, 8'h11);

    // 6: reset during data bit 4 of 0xFF
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    rx_in = 1'b1;
    repeat (32) @(negedge Clk);
    chk("s6_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge Clk);
    chk("s6_rst_data", rx_data, 0);
    chk("s6_rst_valid", rx_valid, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_errs", {parity_err, frame_err, overrun_err}, 0);
    reset = 1'b0;
    repeat (128) @(negedge Clk);
    snap();
    send(8'h0F, 1'b0, 1'b1);
    chk("s6_data", rx_data, 8'h0F);
    chk("s6_rise", n_rise - b_rise, 1);
    chk("s6_errs", (n_pe - b_pe) + (n_fe - b_fe) + (n_ov - b_ov), 0);
    repeat (40) @(negedge Clk);
    chk("s6_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
